out_unload: RTL and testbench

Output-side unloader for the multi-mode FFT: the counterpart of the input bit-reverse resorter. When the FFT core signals completion, it reads the result RAM in natural order 0..N-1. For inverse transforms it applies conjugation and 1/N scaling. It presents the samples as a framed stream with valid, sop and eop. It sits between the in-place butterfly RAM and the block output port.

---
 rtl/out_unload.sv | 146 ++++++++++++++
 tb/tb_out_unload.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/out_unload.sv
// Output unloader for the multi-mode FFT: reads the result RAM in natural order and
// streams it out framed, applying conjugation and 1/N scaling for inverse transforms.
module out_unload (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               inv,
  input  logic        [9:0]  N,
  input  logic signed [15:0] ram_re,
  input  logic signed [15:0] ram_im,
  output logic        [8:0]  addr_unload,
  output logic               rd_en,
  output logic signed [15:0] y_re,
  output logic signed [15:0] y_im,
  output logic               y_valid,
  output logic               sop_out,
  output logic               eop_out,
  output logic               busy,
  output logic               unload_complete
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic        [8:0]  r_cnt;
  logic        [8:0]  r_last;
  logic        [3:0]  r_k;
  logic               r_inv;
  logic               r_drain;
  logic               r_vld1;
  logic               r_sop1;
  logic               r_eop1;
  logic               w_legal;
  logic        [3:0]  w_k;
  logic               w_accept;
  logic               w_lastRead;
  logic               w_drainDone;
  logic signed [15:0] w_negIm;
  logic signed [15:0] w_re;
  logic signed [15:0] w_im;

  always_comb begin
    w_legal = 1'b1;
    w_k     = 4'd6;
    case (N)
      10'd64:  w_k = 4'd6;
      10'd128: w_k = 4'd7;
      10'd256: w_k = 4'd8;
      10'd512: w_k = 4'd9;
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    rd_en       = 1'b0;
    addr_unload = 9'd0;
    busy        = 1'b0;
    w_accept    = 1'b0;
    w_lastRead  = 1'b0;
    w_drainDone = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && w_legal) begin
          w_accept    = 1'b1;
          w_nextState = READ;
        end
      end
      READ: begin
        rd_en       = 1'b1;
        addr_unload = r_cnt;
        busy        = 1'b1;
        if (r_cnt == r_last) begin
          w_lastRead  = 1'b1;
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (r_drain) begin
          w_drainDone = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Frame parameters are captured only on an accepted start, so mid-frame changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt           <= 9'd0;
      r_last          <= 9'd0;
      r_k             <= 4'd0;
      r_inv           <= 1'b0;
      r_drain         <= 1'b0;
      unload_complete <= 1'b0;
    end else begin
      unload_complete <= w_drainDone;
      if (w_accept) begin
        r_cnt  <= 9'd0;
        r_last <= N[8:0] - 9'd1;
        r_k    <= w_k;
        r_inv  <= inv;
      end else if (r_state == READ) begin
        r_cnt <= w_lastRead ? 9'd0 : r_cnt + 9'd1;
      end
      if (r_state == DRAIN) r_drain <= ~r_drain;
      else                  r_drain <= 1'b0;
    end
  end

  // Negating -32768 would wrap, so it saturates to +32767 before the scaling shift.
  assign w_negIm = (ram_im == 16'sh8000) ? 16'sh7FFF : -ram_im;
  assign w_re    = r_inv ? (ram_re  >>> r_k) : ram_re;
  assign w_im    = r_inv ? (w_negIm >>> r_k) : ram_im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld1  <= 1'b0;
      r_sop1  <= 1'b0;
      r_eop1  <= 1'b0;
      y_valid <= 1'b0;
      sop_out <= 1'b0;
      eop_out <= 1'b0;
      y_re    <= 16'sd0;
      y_im    <= 16'sd0;
    end else begin
      r_vld1  <= rd_en;
      r_sop1  <= rd_en && (r_cnt == 9'd0);
      r_eop1  <= w_lastRead;
      y_valid <= r_vld1;
      sop_out <= r_sop1;
      eop_out <= r_eop1;
      y_re    <= r_vld1 ? w_re : 16'sd0;
      y_im    <= r_vld1 ? w_im : 16'sd0;
    end
  end

endmodule

// File: tb/tb_out_unload.sv
// Directed bench for out_unload: table-driven sample vectors on full frames plus
// hand-written sequences for restart, illegal size and mid-frame reset.
module tb_out_unload;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               inv;
  logic        [9:0]  N;
  logic signed [15:0] ramRe;
  logic signed [15:0] ramIm;
  logic        [8:0]  addr_unload;
  logic               rd_en;
  logic signed [15:0] y_re;
  logic signed [15:0] y_im;
  logic               y_valid;
  logic               sop_out;
  logic               eop_out;
  logic               busy;
  logic               unload_complete;

  logic signed [15:0] memRe [512];
  logic signed [15:0] memIm [512];
  int                 capRe [512];
  int                 capIm [512];

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    int n;
    bit iv;
    int idx;
    int re;
    int im;
    int expRe;
    int expIm;
  } vec_t;

  out_unload dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .inv            (inv),
    .N              (N),
    .ram_re         (ramRe),
    .ram_im         (ramIm),
    .addr_unload    (addr_unload),
    .rd_en          (rd_en),
    .y_re           (y_re),
    .y_im           (y_im),
    .y_valid        (y_valid),
    .sop_out        (sop_out),
    .eop_out        (eop_out),
    .busy           (busy),
    .unload_complete(unload_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM: data for the address issued in cycle c appears in cycle c+1.
  always @(posedge clk) begin
    if (rd_en) begin
      ramRe <= memRe[addr_unload];
      ramIm <= memIm[addr_unload];
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int floorShift(input int x, input int k);
    int d;
    d = 1 << k;
    if (x >= 0) return x / d;
    return -(((-x) + d - 1) / d);
  endfunction

  function automatic int kOf(input int n);
    case (n)
      64:      return 6;
      128:     return 7;
      256:     return 8;
      default: return 9;
    endcase
  endfunction

  function automatic int modelRe(input int re, input bit iv, input int n);
    return iv ? floorShift(re, kOf(n)) : re;
  endfunction

  function automatic int modelIm(input int im, input bit iv, input int n);
    int t;
    t = (im == -32768) ? 32767 : -im;
    return iv ? floorShift(t, kOf(n)) : im;
  endfunction

  // Runs one frame; rePulse>0 re-pulses start (with altered N/inv) at that relative cycle,
  // chain=1 raises start for an N=64 forward frame in the unload_complete cycle.
  task automatic applyStimulus(input int n, input bit iv, input bit alreadyStarted,
                               input int rePulse, input bit chain);
    int rdFirst, rdCount, addrErr, vFirst, vCount, sopRel, sopCount;
    int eopRel, eopCount, ucRel, ucCount, busyErr, zeroErr, dataErr;
    rdFirst = -1; rdCount = 0; addrErr = 0; vFirst = -1; vCount = 0;
    sopRel = -1; sopCount = 0; eopRel = -1; eopCount = 0;
    ucRel = -1; ucCount = 0; busyErr = 0; zeroErr = 0; dataErr = 0;
    if (!alreadyStarted) begin
      @(negedge clk);
      N = 10'(n);
      inv = iv;
      start = 1'b1;
    end
    for (int rel = 1; rel <= n + 3; rel++) begin
      @(negedge clk);
      if (rel == 1) start = 1'b0;
      if (rePulse > 0 && rel == rePulse) begin
        start = 1'b1;
        N = 10'd64;
        inv = ~iv;
      end
      if (rePulse > 0 && rel == rePulse + 1) start = 1'b0;
      if (chain && rel == n + 3) begin
        start = 1'b1;
        N = 10'd64;
        inv = 1'b0;
      end
      if (rd_en) begin
        if (rdCount == 0) rdFirst = rel;
        if (int'(addr_unload) != rdCount) addrErr++;
        rdCount++;
      end else if (addr_unload != 9'd0) zeroErr++;
      if (y_valid) begin
        if (vCount == 0) vFirst = rel;
        if (vCount < 512) begin
          capRe[vCount] = int'(y_re);
          capIm[vCount] = int'(y_im);
        end
        if (sop_out) begin sopRel = rel; sopCount++; end
        if (eop_out) begin eopRel = rel; eopCount++; end
        vCount++;
      end else if (y_re != 0 || y_im != 0 || sop_out || eop_out) zeroErr++;
      if (unload_complete) begin ucRel = rel; ucCount++; end
      if (busy != (rel <= n + 2)) busyErr++;
    end
    for (int i = 0; i < n; i++) begin
      if (capRe[i] != modelRe(int'(memRe[i]), iv, n)) dataErr++;
      if (capIm[i] != modelIm(int'(memIm[i]), iv, n)) dataErr++;
    end
    checkOutput("first_read_cycle", rdFirst, 1);
    checkOutput("read_count", rdCount, n);
    checkOutput("addr_order_errors", addrErr, 0);
    checkOutput("first_valid_cycle", vFirst, 3);
    checkOutput("valid_count", vCount, n);
    checkOutput("sop_cycle", sopRel, 3);
    checkOutput("sop_count", sopCount, 1);
    checkOutput("eop_cycle", eopRel, n + 2);
    checkOutput("eop_count", eopCount, 1);
    checkOutput("complete_cycle", ucRel, n + 3);
    checkOutput("complete_count", ucCount, 1);
    checkOutput("busy_errors", busyErr, 0);
    checkOutput("idle_zero_errors", zeroErr, 0);
    checkOutput("data_errors", dataErr, 0);
  endtask

  vec_t vecs [8];
  int   activity;

  initial begin
    vecs[0] = '{64,  1'b0, 10,  10,     -10,    10,     -10};
    vecs[1] = '{512, 1'b1, 5,   1024,   512,    2,      -1};
    vecs[2] = '{512, 1'b1, 6,   -1,     0,      -1,     0};
    vecs[3] = '{64,  1'b1, 0,   0,      -32768, 0,      511};
    vecs[4] = '{64,  1'b1, 3,   -32768, 32767,  -512,   -512};
    vecs[5] = '{128, 1'b1, 127, 300,    -300,   2,      2};
    vecs[6] = '{256, 1'b1, 1,   -257,   255,    -2,     -1};
    vecs[7] = '{64,  1'b0, 63,  -32768, 32767,  -32768, 32767};

    for (int i = 0; i < 512; i++) begin
      memRe[i] = 16'(i);
      memIm[i] = 16'(-i);
    end
    rst_n = 1'b0;
    start = 1'b0;
    inv   = 1'b0;
    N     = 10'd64;
    ramRe = 16'sd0;
    ramIm = 16'sd0;

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                int'({addr_unload, rd_en, y_re, y_im, y_valid, sop_out, eop_out, busy, unload_complete} != '0), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      memRe[vecs[v].idx] = 16'(vecs[v].re);
      memIm[vecs[v].idx] = 16'(vecs[v].im);
      applyStimulus(vecs[v].n, vecs[v].iv, 1'b0, 0, 1'b0);
      checkOutput($sformatf("vec%0d_re", v), capRe[vecs[v].idx], vecs[v].expRe);
      checkOutput($sformatf("vec%0d_im", v), capIm[vecs[v].idx], vecs[v].expIm);
    end

    // Ignored restart mid-frame, then a start coinciding with unload_complete.
    applyStimulus(128, 1'b1, 1'b0, 10, 1'b1);
    applyStimulus(64, 1'b0, 1'b1, 0, 1'b0);

    // Illegal size must never leave IDLE.
    @(negedge clk);
    N = 10'd100;
    start = 1'b1;
    activity = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_en || y_valid || busy || unload_complete) activity++;
    end
    checkOutput("illegal_n_activity", activity, 0);

    // Reset in the middle of an N=256 frame.
    @(negedge clk);
    N = 10'd256;
    inv = 1'b0;
    start = 1'b1;
    for (int rel = 1; rel < 20; rel++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    checkOutput("pre_reset_valid", int'(y_valid), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midframe_reset_outputs",
                int'({addr_unload, rd_en, y_re, y_im, y_valid, sop_out, eop_out, busy, unload_complete} != '0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    activity = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rd_en || y_valid || busy || unload_complete) activity++;
    end
    checkOutput("post_reset_activity", activity, 0);
    applyStimulus(64, 1'b0, 1'b0, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
